// File: rtl/ila_capture_ctrl.sv
`default_nettype none
// ila_capture_ctrl -- arms ila_core, waits for post-trigger samples, then streams the buffer out. Rev 1.0
// Optional macro ILA_CTRL_TIMEOUT_EN adds an ARMED-state timeout (timeout input, timed_out output).
module ila_capture_ctrl #(
  parameter int BUFFER_W = 8,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 2
`ifdef ILA_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic [BUFFER_W-1:0] post_count,
  input  logic [BUFFER_W-1:0] samples,
  input  logic [DATA_W-1:0]   value,
  output logic                rst_soft,
  output logic [BUFFER_W-1:0] index,
  output logic [SEL_W-1:0]    value_select,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
`ifdef ILA_CTRL_TIMEOUT_EN
  , input  logic [TIMEOUT_W-1:0] timeout,
  output logic                   timed_out
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam logic [BUFFER_W:0] N_FULL = {1'b1, {BUFFER_W{1'b0}}};

  logic [2:0]          state_q, state_d;
  logic [BUFFER_W-1:0] pc_q, pc_d;
  logic [BUFFER_W:0]   n_q, n_d;
  logic [BUFFER_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                last_word;
`ifdef ILA_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic                 tmo_q, tmo_d;
`endif

  assign last_word = ({1'b0, idx_q} == (n_q - (BUFFER_W+1)'(1))) && (sel_q == '1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
`ifdef ILA_CTRL_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arm && !abort) begin
          state_d = S_CLEAR;
          pc_d    = post_count;
          done_d  = 1'b0;
`ifdef ILA_CTRL_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_CLEAR: begin
        state_d = S_ARMED;
`ifdef ILA_CTRL_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      S_ARMED: begin
        if (samples != '0) begin
          state_d = S_CAPTURE;
        end
`ifdef ILA_CTRL_TIMEOUT_EN
        else if ((timeout != '0) && ((tcnt_q + TIMEOUT_W'(1)) == timeout)) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          tcnt_d  = tcnt_q + TIMEOUT_W'(1);
        end
`endif
      end
      S_CAPTURE: begin
        // post_count 0 means a full buffer: wait for the count to wrap back to zero
        if (pc_q == '0) begin
          if (samples == '0) begin
            state_d = S_READ;
            n_d     = N_FULL;
          end
        end else if (samples >= pc_q) begin
          state_d = S_READ;
          n_d     = {1'b0, samples};
        end
      end
      S_READ: begin
        // One word per two cycles: load at the presented address, then wait for acceptance
        if (!valid_q) begin
          data_d  = value;
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          if (last_word) begin
            state_d = S_DRAIN;
          end else if (sel_q == '1) begin
            sel_d = '0;
            idx_d = idx_q + BUFFER_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      done_d  = done_q;
    end
    if (state_d != S_READ) begin
      idx_d = '0;
      sel_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ILA_CTRL_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef ILA_CTRL_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign rst_soft     = (state_q == S_CLEAR);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign index        = idx_q;
  assign value_select = sel_q;
  assign out_data     = data_q;
  assign out_valid    = valid_q;
`ifdef ILA_CTRL_TIMEOUT_EN
  assign timed_out    = tmo_q;
`endif

endmodule
`default_nettype wire

// File: doc/ila_capture_ctrl.md
ILA_CAPTURE_CTRL -- requirements
Module: ila_capture_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_W, default 8, sample-buffer address width (matches ila_core BUFFER_W).
REQ-002 SHALL have parameter DATA_W, default 32, readout word width.
REQ-003 SHALL have parameter SEL_W, default 2, value_select width; words per sample = 2^SEL_W.
REQ-004 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port arm  in  1  one-cycle pulse, start capture.
REQ-007 SHALL have port abort  in  1  one-cycle pulse, return to IDLE.
REQ-008 SHALL have port post_count  in  BUFFER_W  samples to capture before stop; 0 means 2^BUFFER_W.
REQ-009 SHALL have port samples  in  BUFFER_W  sample count from ila_core.
REQ-010 SHALL have port value  in  DATA_W  word from ila_core at (index, value_select).
REQ-011 SHALL have port rst_soft  out  1  soft clear to ila_core.
REQ-012 SHALL have port index  out  BUFFER_W  sample address to ila_core.
REQ-013 SHALL have port value_select  out  SEL_W  word select to ila_core.
REQ-014 SHALL have ports out_data  out  DATA_W, out_valid  out  1, out_ready  in  1  readout stream.
REQ-015 SHALL have ports busy  out  1 (state not IDLE) and done  out  1 (readout complete, sticky until next arm).

Function
REQ-016 SHALL implement states IDLE, CLEAR, ARMED, CAPTURE, READ, DRAIN.
REQ-017 IDLE + arm SHALL go to CLEAR; post_count SHALL be latched at that edge; done SHALL clear.
REQ-018 CLEAR SHALL assert rst_soft for exactly one cycle, then go to ARMED.
REQ-019 ARMED SHALL go to CAPTURE when samples != 0 (first triggered sample stored).
REQ-020 CAPTURE SHALL go to READ when samples >= latched post_count (post_count 0: when samples wraps to 0 after being nonzero); latched count of stored samples N = samples at that edge (or 2^BUFFER_W).
REQ-021 READ SHALL present index/value_select, register value into out_data one cycle later, and assert out_valid; index/value_select SHALL advance only on out_valid && out_ready.
REQ-022 Address order SHALL be value_select 0..2^SEL_W-1 innermost, index 0..N-1 outer; total words = N*2^SEL_W.
REQ-023 out_data SHALL hold stable while out_valid && !out_ready.
REQ-024 After last word accepted, SHALL go to DRAIN for one cycle, set done, return to IDLE.
REQ-025 abort in any non-IDLE state SHALL go to IDLE next edge, deassert out_valid, leave done 0.
REQ-026 arm while busy SHALL be ignored; arm and abort same cycle: abort wins.
REQ-027 index, value_select SHALL be 0 outside READ.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, rst_soft 0, index 0, value_select 0, out_data 0, out_valid 0, busy 0, done 0, latched post_count 0.
REQ-029 Reset mid-READ SHALL discard remaining words; no out_valid after release until a new arm.

Configuration
REQ-030 Macro ILA_CTRL_TIMEOUT_EN defined: SHALL add parameter TIMEOUT_W (default 16) and input timeout [TIMEOUT_W]; ARMED SHALL count cycles and, on reaching timeout (nonzero), go to IDLE, set output timed_out (sticky until next arm), done 0.
REQ-031 Macro undefined: no timeout port, counter, or timed_out port; ARMED waits indefinitely.

Verification
REQ-032 arm, post_count 4, samples 0->1..4 -> rst_soft one cycle after arm; READ entered after samples=4; 16 words (SEL_W 2) streamed index 0..3, select 0..3; done=1.
REQ-033 out_ready held low 5 cycles mid-READ -> out_data, index, value_select unchanged; no word lost or duplicated.
REQ-034 abort during CAPTURE -> IDLE next cycle, busy 0, done 0, out_valid never asserted.
REQ-035 post_count 0, BUFFER_W 8, samples wraps 255->0 -> 256*4 words streamed.
REQ-036 rst low during READ word 7 -> all outputs 0 immediately; re-arm produces full sequence from index 0.
REQ-037 ILA_CTRL_TIMEOUT_EN, timeout 10, samples stays 0 -> IDLE 10 cycles after ARMED entry, timed_out 1, done 0.
